// File: rtl/proc_pkg.sv
// Shared definitions for the program loader: FSM state encoding, default
// memory depth and the RISC-V NOP encoding used as filler by callers.
package proc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RELEASE,
        ST_RUN,
        ST_ERROR
    } loader_state_e;

    localparam int unsigned MEM_DEPTH_DEFAULT = 16384;
    localparam int unsigned BYTES_PER_WORD    = 4;
    localparam logic [31:0] NOP_INSN          = 32'h0000_0013;

endpackage

// File: rtl/word_serializer.sv
// Holds one accepted word and presents it one byte per cycle, byte 0 first,
// reporting to the loader FSM when it is on its final byte or free.
module word_serializer
    import proc_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] word_i,
    output logic             busy_o,
    output logic             on_last_o,
    output logic             emit_o,
    output logic             ready_next_o,
    output logic [7:0]       byte_o
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic             busy_q, busy_d;
    logic [1:0]       idx_q, idx_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [7:0]       byte_q, byte_d;

    always_comb begin
        busy_d  = busy_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        byte_d  = byte_q;
        if (load_i) begin
            busy_d  = 1'b1;
            idx_d   = '0;
            byte_d  = word_i[7:0];
            shreg_d = word_i >> 8;
        end else if (busy_q) begin
            if (idx_q == LAST_IDX) begin
                busy_d = 1'b0;
            end else begin
                byte_d  = shreg_q[7:0];
                shreg_d = shreg_q >> 8;
                idx_d   = idx_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q  <= 1'b0;
            idx_q   <= '0;
            shreg_q <= '0;
            byte_q  <= '0;
        end else begin
            busy_q  <= busy_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            byte_q  <= byte_d;
        end
    end

    assign busy_o    = busy_q;
    assign byte_o    = byte_q;
    assign on_last_o = busy_q && (idx_q == LAST_IDX);
    assign emit_o    = load_i || (busy_q && (idx_q != LAST_IDX));
    // Free next cycle if idle, or about to reach / leave the final byte.
    assign ready_next_o = !load_i && (!busy_q || (idx_q >= LAST_IDX - 2'd1));

endmodule

// File: rtl/prog_loader.sv
// Streams a program image into processor memory bytewise, holding the CPU in
// reset until loaded. Define LOADER_CHECKSUM_EN to add the checksum output.
module prog_loader
    import proc_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned MEM_DEPTH      = MEM_DEPTH_DEFAULT,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned RELEASE_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             word_valid,
    input  logic [WIDTH-1:0] word_data,
    input  logic             word_last,
    output logic             word_ready,
    output logic             memEn,
    output logic [WIDTH-1:0] memAddr,
    output logic [WIDTH-1:0] memData,
    output logic             cpu_reset,
    output logic             done,
    output logic             error
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0] checksum
`endif
);

    localparam int unsigned REL_LAST = (RELEASE_CYCLES > 0) ? RELEASE_CYCLES - 1 : 0;
    localparam int unsigned REL_W    = $clog2(REL_LAST + 1) + 1;

    loader_state_e    state_q, state_d;
    logic [WIDTH-1:0] ptr_q, ptr_d, addr_q, addr_d;
    logic [REL_W-1:0] rel_q, rel_d;
    logic             last_q, last_d;
    logic             ready_q, ready_d, cpu_rst_q, cpu_rst_d;
    logic             done_q, done_d, err_q, err_d;
    logic             load, restart, overflow;
    logic [WIDTH:0]   end_addr;
    logic             ser_busy, ser_on_last, ser_emit, ser_ready_next;
    logic [7:0]       ser_byte;

    word_serializer #(.WIDTH(WIDTH)) u_ser (
        .clk_i        (clock),
        .rst_i        (reset),
        .load_i       (load),
        .word_i       (word_data),
        .busy_o       (ser_busy),
        .on_last_o    (ser_on_last),
        .emit_o       (ser_emit),
        .ready_next_o (ser_ready_next),
        .byte_o       (ser_byte)
    );

    // ptr_q is the next unwritten byte address; extra bit keeps the bound check wrap-free.
    assign end_addr = {1'b0, ptr_q} + (WIDTH+1)'(BYTES_PER_WORD - 1);
    assign overflow = end_addr > (WIDTH+1)'(MEM_DEPTH - 1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        last_d  = last_q;
        rel_d   = rel_q;
        load    = 1'b0;
        restart = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_RUN, ST_ERROR: begin
                if (start) begin
                    state_d = ST_LOAD;
                    restart = 1'b1;
                end
            end
            ST_LOAD: begin
                if (word_valid && ready_q) begin
                    if (overflow) begin
                        state_d = ST_ERROR;
                    end else begin
                        load   = 1'b1;
                        last_d = word_last;
                    end
                end
                if (ser_on_last && last_q) begin
                    state_d = (RELEASE_CYCLES == 0) ? ST_RUN : ST_RELEASE;
                    rel_d   = '0;
                    last_d  = 1'b0;
                end
            end
            ST_RELEASE: begin
                if (rel_q == REL_W'(REL_LAST)) state_d = ST_RUN;
                else                           rel_d   = rel_q + REL_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        if (restart) begin
            ptr_d  = WIDTH'(BASE_ADDR);
            last_d = 1'b0;
        end
        if (ser_emit) begin
            addr_d = ptr_q;
            ptr_d  = ptr_q + WIDTH'(1);
        end
        ready_d   = (state_d == ST_LOAD) && !last_d && ser_ready_next;
        cpu_rst_d = (state_d != ST_RUN);
        done_d    = (state_d == ST_RUN);
        err_d     = (state_d == ST_ERROR);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            addr_q    <= '0;
            last_q    <= 1'b0;
            rel_q     <= '0;
            ready_q   <= 1'b0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            addr_q    <= addr_d;
            last_q    <= last_d;
            rel_q     <= rel_d;
            ready_q   <= ready_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (restart)   csum_d = '0;
        else if (load) csum_d = csum_q + word_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) csum_q <= '0;
        else       csum_q <= csum_d;
    end

    assign checksum = csum_q;
`endif

    assign word_ready = ready_q;
    assign memEn      = ser_busy;
    assign memAddr    = addr_q;
    assign memData    = {{(WIDTH-8){1'b0}}, ser_byte};
    assign cpu_reset  = cpu_rst_q;
    assign done       = done_q;
    assign error      = err_q;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: WIDTH, 32, data and address width.
REQ-002 Parameter: MEM_DEPTH, 16384, byte capacity of processor main memory.
REQ-003 Parameter: BASE_ADDR, 0, first byte address written.
REQ-004 Parameter: RELEASE_CYCLES, 2, cycles cpu_reset stays high after the final byte write.
REQ-005 clock  input  1  single clock; all state updates on posedge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle pulse; begins a load session.
REQ-008 word_valid  input  1  program word available.
REQ-009 word_data  input  WIDTH  instruction/data word, little-endian byte order.
REQ-010 word_last  input  1  qualifies word_data as final image word.
REQ-011 word_ready  output  1  loader accepts word this cycle.
REQ-012 memEn  output  1  byte-write strobe into processor load port.
REQ-013 memAddr  output  WIDTH  byte address for memEn write.
REQ-014 memData  output  WIDTH  byte in [7:0]; [31:8] zero.
REQ-015 cpu_reset  output  1  drives processor reset.
REQ-016 done  output  1  image loaded, processor running.
REQ-017 error  output  1  image overflowed MEM_DEPTH.

Function
REQ-018 All outputs registered; FSM states IDLE, LOAD, RELEASE, RUN, ERROR.
REQ-019 IDLE: cpu_reset=1, word_ready=0, memEn=0; start -> LOAD, address counter := BASE_ADDR.
REQ-020 LOAD: word_ready=1 when no word is held or the held word is on byte 3; transfer on word_valid & word_ready.
REQ-021 Accepted word is serialised byte 0 first, one byte per cycle for 4 cycles: memEn=1, memAddr=counter, memData={24'b0,byte}; counter +1 per byte.
REQ-022 Back-to-back words sustain exactly 4 cycles/word with memEn continuously high; first memEn cycle is the cycle after acceptance.
REQ-023 word_valid low in LOAD: memEn=0 after the held word drains; counter unchanged; no timeout.
REQ-024 After byte 3 of a word_last word: -> RELEASE; memEn=0; cpu_reset held 1 for RELEASE_CYCLES cycles, then RUN.
REQ-025 RUN: cpu_reset=0, done=1, word_ready=0; start -> LOAD with cpu_reset=1 and done=0 in the next cycle.
REQ-026 Overflow: accepting a word whose byte 3 address would exceed MEM_DEPTH-1 is refused (no bytes written) -> ERROR.
REQ-027 ERROR: error=1, cpu_reset=1, memEn=0, word_ready=0; start clears error and -> LOAD.
REQ-028 start while LOAD or RELEASE is ignored.
REQ-029 Address counter is WIDTH bits and never wraps; overflow detected per REQ-026.

Reset
REQ-030 reset asserted at any time, including mid-word: state IDLE, memEn=0, memAddr=0, memData=0, word_ready=0, cpu_reset=1, done=0, error=0, counters 0; partial word discarded.

Configuration
REQ-031 Macro LOADER_CHECKSUM_EN defined: extra output checksum (WIDTH) = modulo-2^WIDTH sum of accepted words, cleared on start and reset, frozen in RUN/ERROR.
REQ-032 Macro LOADER_CHECKSUM_EN undefined: no checksum port or logic; all other behaviour identical.

Structure
REQ-033 Shared package proc_pkg holds the loader state enum, MEM_DEPTH default, and NOP encoding 32'h00000013.
REQ-034 One sub-module, word_serializer: holds one word, emits 4 bytes, reports drain state to the FSM.

Verification
REQ-035 start, words 32'h00000013 and 32'hDEADBEEF (last) back-to-back -> memEn high 8 consecutive cycles, addr 0..7, bytes 13,00,00,00,EF,BE,AD,DE; cpu_reset falls 2 cycles after last byte; done=1.
REQ-036 word_valid gaps of 3 cycles between words -> memEn gaps, addresses contiguous, no duplicated or lost bytes.
REQ-037 BASE_ADDR=16380, two words -> first word at 16380..16383, second refused, error=1, cpu_reset=1.
REQ-038 reset asserted after byte 1 of a word -> next cycle memEn=0, cpu_reset=1, IDLE; fresh start reloads from BASE_ADDR.
REQ-039 start pulsed during LOAD -> ignored; start in RUN -> cpu_reset=1 next cycle, reload from BASE_ADDR.
REQ-040 LOADER_CHECKSUM_EN build, words 1, 2, 32'hFFFFFFFF -> checksum 32'h00000002.
